// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit and the decode logic that drives it.
// The op encodings, the FSM state encoding and the default timeout live here.
package mem_access_unit_pkg;

    localparam int MEM_OP_BITS = 2;

    localparam logic [MEM_OP_BITS-1:0] MEM_OP_NOP   = 2'd0;
    localparam logic [MEM_OP_BITS-1:0] MEM_OP_READ  = 2'd1;
    localparam logic [MEM_OP_BITS-1:0] MEM_OP_WRITE = 2'd2;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_write(input logic [MEM_OP_BITS-1:0] op);
        return op == MEM_OP_WRITE;
    endfunction

endpackage

// File: rtl/mem_access_unit_timeout_counter.sv
// Wait counter for memory requests.
// tc_o flags the enabled cycle whose increment would bring the count up to TIMEOUT.
module mem_timeout_counter
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = enable_i && (count_q == TC_VAL);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns a decoded load/store into a req/ack handshake, holding the
// pipeline while the access is outstanding and giving up after TIMEOUT unacknowledged cycles.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MEM_OP_BITS-1:0] mem_op,
    input  logic                   address_src,
    input  logic [ADDR_WIDTH-1:0]  addr_reg,
    input  logic [ADDR_WIDTH-1:0]  addr_imm,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   stall,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   done,
    output logic                   err,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic                   mem_ack,
    input  logic [DATA_WIDTH-1:0]  mem_rdata
);

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    done_q;
    logic                    err_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;

    logic                    accept;
    logic                    wait_en;
    logic                    timeout_hit;
    logic [ADDR_WIDTH-1:0]   sel_addr;

    assign accept   = (state_q == ST_IDLE) && (mem_op != MEM_OP_NOP);
    assign wait_en  = (state_q == ST_REQ) && !mem_ack;
    assign sel_addr = address_src ? addr_imm : addr_reg;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (accept),
        .enable_i (wait_en),
        .tc_o     (timeout_hit)
    );

    // mem_we_q doubles as the latched direction while in REQ; it is only cleared on exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= wr_data;
                        mem_we_q    <= is_write(mem_op);
                        mem_req_q   <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (mem_ack) begin
                        if (!mem_we_q) begin
                            rd_data_q <= mem_rdata;
                        end
                        err_q     <= 1'b0;
                        done_q    <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= ST_DONE;
                    end else if (timeout_hit) begin
                        if (!mem_we_q) begin
                            rd_data_q <= '0;
                        end
                        err_q     <= 1'b1;
                        done_q    <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall     = accept || (state_q == ST_REQ);
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: read, write, timeout, ack-at-boundary,
// reset mid-request and back-to-back ops. Inputs change and outputs are checked on negedges.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic                   clk;
    logic                   reset;
    logic [MEM_OP_BITS-1:0] mem_op;
    logic                   address_src;
    logic [15:0]            addr_reg;
    logic [15:0]            addr_imm;
    logic [31:0]            wr_data;
    logic                   stall;
    logic [31:0]            rd_data;
    logic                   done;
    logic                   err;
    logic                   mem_req;
    logic                   mem_we;
    logic [15:0]            mem_addr;
    logic [31:0]            mem_wdata;
    logic                   mem_ack;
    logic [31:0]            mem_rdata;

    int total = 0;
    int bad   = 0;
    int req_cnt;

    mem_access_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .TIMEOUT    (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_op      (mem_op),
        .address_src (address_src),
        .addr_reg    (addr_reg),
        .addr_imm    (addr_imm),
        .wr_data     (wr_data),
        .stall       (stall),
        .rd_data     (rd_data),
        .done        (done),
        .err         (err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; mem_op = MEM_OP_NOP; address_src = 1'b0;
        addr_reg = '0; addr_imm = '0; wr_data = '0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        nxt();
        chk("rst_stall",   32'(stall),    32'd0);
        chk("rst_done",    32'(done),     32'd0);
        chk("rst_err",     32'(err),      32'd0);
        chk("rst_req",     32'(mem_req),  32'd0);
        chk("rst_we",      32'(mem_we),   32'd0);
        chk("rst_rdata",   rd_data,       32'd0);
        chk("rst_addr",    32'(mem_addr), 32'd0);
        chk("rst_wdata",   mem_wdata,     32'd0);
        reset = 1'b0;
        nxt();
        chk("idle_nop_stall", 32'(stall), 32'd0);

        // Read, ack in third REQ cycle
        mem_op = MEM_OP_READ; address_src = 1'b0; addr_reg = 16'h0040; addr_imm = 16'h9999;
        #1 chk("rd_stall_accept", 32'(stall), 32'd1);
        nxt();
        mem_op = MEM_OP_NOP; addr_reg = 16'h7777;
        chk("rd_req1",   32'(mem_req),  32'd1);
        chk("rd_we",     32'(mem_we),   32'd0);
        chk("rd_addr",   32'(mem_addr), 32'h0040);
        chk("rd_stall1", 32'(stall),    32'd1);
        nxt();
        chk("rd_stall2", 32'(stall),    32'd1);
        chk("rd_addr2",  32'(mem_addr), 32'h0040);
        nxt();
        chk("rd_stall3", 32'(stall),    32'd1);
        chk("rd_done_early", 32'(done), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        nxt();
        mem_ack = 1'b0;
        chk("rd_done",   32'(done),    32'd1);
        chk("rd_err",    32'(err),     32'd0);
        chk("rd_data",   rd_data,      32'hDEADBEEF);
        chk("rd_stall_done", 32'(stall), 32'd0);
        chk("rd_req_done",   32'(mem_req), 32'd0);
        nxt();
        chk("rd_done_once", 32'(done), 32'd0);

        // Write via immediate address, immediate ack
        mem_op = MEM_OP_WRITE; address_src = 1'b1; addr_imm = 16'h1234; wr_data = 32'hA5A5A5A5;
        nxt();
        mem_op = MEM_OP_NOP; wr_data = 32'h0;
        chk("wr_req",   32'(mem_req),  32'd1);
        chk("wr_we",    32'(mem_we),   32'd1);
        chk("wr_addr",  32'(mem_addr), 32'h1234);
        chk("wr_wdata", mem_wdata,     32'hA5A5A5A5);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        nxt();
        mem_ack = 1'b0;
        chk("wr_done",     32'(done),     32'd1);
        chk("wr_rd_keep",  rd_data,       32'hDEADBEEF);
        chk("wr_we_done",  32'(mem_we),   32'd0);
        chk("wr_addr_hold", 32'(mem_addr), 32'h1234);
        nxt();

        // Stray ack in IDLE
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        nxt();
        mem_ack = 1'b0;
        chk("stray_done",  32'(done),  32'd0);
        chk("stray_req",   32'(mem_req), 32'd0);
        chk("stray_rdata", rd_data,    32'hDEADBEEF);

        // Timeout read
        mem_op = MEM_OP_READ; address_src = 1'b0; addr_reg = 16'h0100;
        req_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            nxt();
            mem_op = MEM_OP_NOP;
            if (mem_req) req_cnt++;
        end
        chk("to_req_cycles", 32'(req_cnt), 32'd15);
        nxt();
        chk("to_done",  32'(done),    32'd1);
        chk("to_err",   32'(err),     32'd1);
        chk("to_rdata", rd_data,      32'd0);
        chk("to_req_off", 32'(mem_req), 32'd0);
        nxt();
        chk("to_idle_done", 32'(done), 32'd0);
        chk("to_idle_stall", 32'(stall), 32'd0);

        // Ack on the timeout boundary cycle
        mem_op = MEM_OP_READ; addr_reg = 16'h0104;
        for (int i = 0; i < 15; i++) begin
            nxt();
            mem_op = MEM_OP_NOP;
        end
        chk("bnd_req_last", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        nxt();
        mem_ack = 1'b0;
        chk("bnd_done",  32'(done), 32'd1);
        chk("bnd_err",   32'(err),  32'd0);
        chk("bnd_rdata", rd_data,   32'h12345678);
        nxt();

        // Reset during REQ cycle 2
        mem_op = MEM_OP_READ; addr_reg = 16'h0200;
        nxt();
        mem_op = MEM_OP_NOP;
        nxt();
        chk("rr_req_before", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rr_req_drop",   32'(mem_req), 32'd0);
        chk("rr_stall_drop", 32'(stall),   32'd0);
        chk("rr_rdata_clr",  rd_data,      32'd0);
        nxt();
        chk("rr_no_done", 32'(done), 32'd0);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        nxt();
        mem_ack = 1'b0;
        chk("rr_stray_done",  32'(done),    32'd0);
        chk("rr_stray_req",   32'(mem_req), 32'd0);
        chk("rr_stray_rdata", rd_data,      32'd0);
        mem_op = MEM_OP_READ; addr_reg = 16'h0208;
        nxt();
        mem_op = MEM_OP_NOP;
        chk("rr_next_addr", 32'(mem_addr), 32'h0208);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        nxt();
        mem_ack = 1'b0;
        chk("rr_next_done",  32'(done), 32'd1);
        chk("rr_next_rdata", rd_data,   32'hCAFEF00D);
        nxt();

        // Back-to-back: READ then WRITE held through DONE
        mem_op = MEM_OP_READ; address_src = 1'b0; addr_reg = 16'h0300;
        nxt();
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        mem_op = MEM_OP_WRITE; address_src = 1'b1; addr_imm = 16'h0400; wr_data = 32'h5555AAAA;
        chk("b2b_rd_addr", 32'(mem_addr), 32'h0300);
        nxt();
        mem_ack = 1'b0;
        chk("b2b_rd_done",    32'(done),    32'd1);
        chk("b2b_rd_data",    rd_data,      32'h11112222);
        chk("b2b_done_stall", 32'(stall),   32'd0);
        nxt();
        chk("b2b_no_accept_in_done", 32'(mem_req), 32'd0);
        chk("b2b_idle_stall",        32'(stall),   32'd1);
        nxt();
        mem_op = MEM_OP_NOP;
        chk("b2b_wr_req",  32'(mem_req),  32'd1);
        chk("b2b_wr_we",   32'(mem_we),   32'd1);
        chk("b2b_wr_addr", 32'(mem_addr), 32'h0400);
        chk("b2b_wr_data", mem_wdata,     32'h5555AAAA);
        mem_ack = 1'b1;
        nxt();
        mem_ack = 1'b0;
        chk("b2b_wr_done",   32'(done), 32'd1);
        chk("b2b_rd_keep",   rd_data,   32'h11112222);
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameters DATA_WIDTH, default 32, data word width; ADDR_WIDTH, default 16, memory address width; TIMEOUT, default 15, maximum cycles to wait for mem_ack.
REQ-002 SHALL have ports, in order:
- clk  in  1  only clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_op  in  MEM_OP_BITS  memory operation from decode: MEM_OP_NOP, MEM_OP_READ or MEM_OP_WRITE.
- address_src  in  1  address select: 0 = addr_reg, 1 = addr_imm.
- addr_reg  in  ADDR_WIDTH  register/ALU-computed address.
- addr_imm  in  ADDR_WIDTH  absolute address from the instruction.
- wr_data  in  DATA_WIDTH  store data.
- stall  out  1  pipeline hold request.
- rd_data  out  DATA_WIDTH  load result.
- done  out  1  one-cycle completion pulse.
- err  out  1  timeout flag, qualified by done.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ack  in  1  memory accept/complete, single-cycle pulse.
- mem_rdata  in  DATA_WIDTH  read data, valid in the mem_ack cycle.

Function
REQ-003 SHALL implement FSM states IDLE, REQ and DONE.
REQ-004 In IDLE with mem_op != MEM_OP_NOP, SHALL latch the selected address, wr_data and we = (mem_op == MEM_OP_WRITE), and SHALL go to REQ.
REQ-005 SHALL drive stall combinationally high in IDLE when mem_op != MEM_OP_NOP, and high throughout REQ; stall SHALL be low in DONE.
REQ-006 In REQ, SHALL drive mem_req = 1, with mem_we, mem_addr and mem_wdata from the latched values, held stable until mem_ack or timeout.
REQ-007 In REQ, mem_ack = 1 SHALL capture mem_rdata into rd_data (reads only; writes leave rd_data unchanged), clear err and go to DONE; minimum latency from acceptance to done is 2 cycles.
REQ-008 A wait counter SHALL clear on REQ entry and increment each REQ cycle without mem_ack; if it reaches TIMEOUT, the FSM SHALL go to DONE with err = 1, and rd_data = 0 for reads.
REQ-009 mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-010 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE unconditionally; mem_op is ignored in DONE.
REQ-011 mem_ack outside REQ SHALL be ignored, with no state or output change.
REQ-012 Outside REQ, mem_req and mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-013 Inputs SHALL be sampled only at acceptance; input changes during REQ SHALL have no effect.
REQ-014 A MEM_OP_NOP in IDLE SHALL leave all state unchanged.

Reset
REQ-015 reset SHALL asynchronously force state = IDLE, counter = 0, and stall, done, err, mem_req, mem_we = 0; rd_data, mem_addr, mem_wdata = 0.
REQ-016 Reset asserted during REQ SHALL drop mem_req in the same cycle, with no done pulse; an outstanding ack after release SHALL be ignored per REQ-011.

Structure
REQ-017 State encoding, MEM_OP_* encodings, MEM_OP_BITS and the TIMEOUT default SHALL live in the shared defines file used by the decode logic.
REQ-018 The wait counter SHALL be a sub-module, mem_timeout_counter (clear, enable, terminal-count output), and the rest SHALL be flat.

Verification
REQ-019 Read: mem_op = READ, address_src = 0, addr_reg = 0x0040; ack after 3 REQ cycles with mem_rdata = 0xDEADBEEF -> mem_addr = 0x0040, mem_we = 0, rd_data = 0xDEADBEEF, done pulse, err = 0, stall high 4 cycles.
REQ-020 Write: mem_op = WRITE, address_src = 1, addr_imm = 0x1234, wr_data = 0xA5A5A5A5; ack immediately -> mem_we = 1, mem_addr = 0x1234, done 2 cycles after acceptance, rd_data unchanged.
REQ-021 Timeout: read with no ack -> mem_req high for TIMEOUT = 15 cycles, then done with err = 1, rd_data = 0, FSM back in IDLE.
REQ-022 Ack at the boundary: ack in the same cycle the counter reaches TIMEOUT -> err = 0, data captured.
REQ-023 Reset during REQ (cycle 2): mem_req and stall drop immediately, no done; a stray ack after release is ignored; a next READ completes normally.
REQ-024 Back-to-back: READ then WRITE held on mem_op -> second op accepted in the IDLE cycle after DONE, never during DONE.
